// File: rtl/ps2_pkg.sv
// Shared constants and frame-state encoding for the PS/2 scan-code receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
    localparam int         PS2_PAUSE_SKIP = 7;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus stability filter; emits a one-cycle pulse
// on each falling edge of the filtered line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic line_raw,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_raw};
            fall   <= 1'b0;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                // FILTER_LEN-th differing sample: commit the new level
                filt_q <= sync_q[1];
                cnt_q  <= '0;
                fall   <= filt_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 set-2 receive front end: frame deserialiser plus E0/F0/E1 prefix decode.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 3125
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] RX_SCAN,
    output logic       RX_PRESSED,
    output logic       RX_EXTENDED,
    output logic       RX_VALID,
    output logic       RX_ERROR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic [1:0]    dsync_q;
    logic          din;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic [7:0]    scan_d;
    logic          pressed_d, extd_d, valid_d, error_d;
    logic          tmo_hit, skipping;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filt (
        .CLK      (CLK),
        .RESET    (RESET),
        .line_raw (PS2_CLK),
        .fall     (fall)
    );

    assign din      = dsync_q[1];
    assign tmo_hit  = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));
    assign skipping = (skip_q != 3'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dsync_q     <= 2'b11;
            state_q     <= IDLE;
            bit_q       <= '0;
            shreg_q     <= '0;
            par_ok_q    <= 1'b1;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= '0;
            RX_SCAN     <= 8'h00;
            RX_PRESSED  <= 1'b0;
            RX_EXTENDED <= 1'b0;
            RX_VALID    <= 1'b0;
            RX_ERROR    <= 1'b0;
        end else begin
            dsync_q     <= {dsync_q[0], PS2_DATA};
            state_q     <= state_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            RX_SCAN     <= scan_d;
            RX_PRESSED  <= pressed_d;
            RX_EXTENDED <= extd_d;
            RX_VALID    <= valid_d;
            RX_ERROR    <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_ok_d  = par_ok_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        scan_d    = RX_SCAN;
        pressed_d = RX_PRESSED;
        extd_d    = RX_EXTENDED;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        tmo_d     = '0;
        if (!fall && state_q != IDLE)
            tmo_d = tmo_q + TW'(1);

        // An edge always takes priority over a coincident timeout
        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {din, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_ok_d = ^{shreg_q, din};
`else
                    par_ok_d = 1'b1;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (din && par_ok_q) begin
                        unique case (1'b1)
                            skipping: begin
                                skip_d = skip_q - 3'd1;
                            end
                            (!skipping && shreg_q == PS2_PFX_EXT): begin
                                ext_d = 1'b1;
                            end
                            (!skipping && shreg_q == PS2_PFX_BRK): begin
                                brk_d = 1'b1;
                            end
                            (!skipping && shreg_q == PS2_PFX_PAUSE): begin
                                skip_d = 3'(PS2_PAUSE_SKIP);
                            end
                            default: begin
                                scan_d    = shreg_q;
                                pressed_d = ~brk_q;
                                extd_d    = ext_q;
                                valid_d   = 1'b1;
                                ext_d     = 1'b0;
                                brk_d     = 1'b0;
                            end
                        endcase
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = IDLE;
            tmo_d   = '0;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            skip_d  = '0;
            error_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: expected events queued as frames are sent.
module tb_ps2_scan_rx;

    localparam int HALF = 25;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] RX_SCAN;
    logic       RX_PRESSED;
    logic       RX_EXTENDED;
    logic       RX_VALID;
    logic       RX_ERROR;

    always #5 CLK = ~CLK;

    ps2_scan_rx #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (3125)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .RX_SCAN     (RX_SCAN),
        .RX_PRESSED  (RX_PRESSED),
        .RX_EXTENDED (RX_EXTENDED),
        .RX_VALID    (RX_VALID),
        .RX_ERROR    (RX_ERROR)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] scan;
        logic       pressed;
        logic       ext;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        got_e;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] last_scan = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        if (obs === expv)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic push_ev(input logic err, input logic [7:0] scan,
                           input logic pr, input logic ex);
        ev_t e;
        e.err     = err;
        e.scan    = scan;
        e.pressed = pr;
        e.ext     = ex;
        exp_q.push_back(e);
        if (!err)
            last_scan = scan;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = bits[i];
            if (i == glitch_at) begin
                wait_cyc(5);
                PS2_CLK = 1'b0;
                wait_cyc(2);
                PS2_CLK = 1'b1;
                wait_cyc(HALF - 7);
            end else begin
                wait_cyc(HALF);
            end
            PS2_CLK = 1'b0;
            wait_cyc(HALF);
            PS2_CLK = 1'b1;
        end
        wait_cyc(HALF);
        PS2_DATA = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par,
                             input int glitch_at);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11, glitch_at);
    endtask

    always @(negedge CLK) begin
        if (!RESET && (RX_VALID || RX_ERROR)) begin
            chk("valid_err_excl", {31'b0, RX_VALID & RX_ERROR}, 32'd0);
            chk("evt_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                got_e = exp_q.pop_front();
                chk("evt_kind", {31'b0, RX_ERROR}, {31'b0, got_e.err});
                chk("evt_scan", {24'b0, RX_SCAN}, {24'b0, got_e.scan});
                if (!got_e.err) begin
                    chk("evt_pressed", {31'b0, RX_PRESSED},
                        {31'b0, got_e.pressed});
                    chk("evt_ext", {31'b0, RX_EXTENDED},
                        {31'b0, got_e.ext});
                end
            end
        end
    end

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                      8'hF0, 8'h14, 8'hF0, 8'h77};

        wait_cyc(5);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_scan", {24'b0, RX_SCAN}, 32'h00);
        chk("rst_pressed", {31'b0, RX_PRESSED}, 32'd0);
        chk("rst_ext", {31'b0, RX_EXTENDED}, 32'd0);
        chk("rst_valid", {31'b0, RX_VALID}, 32'd0);
        chk("rst_error", {31'b0, RX_ERROR}, 32'd0);

        push_ev(1'b0, 8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C, 1'b0, -1);

        push_ev(1'b0, 8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h1C, 1'b0, -1);

        push_ev(1'b0, 8'h75, 1'b1, 1'b1);
        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'h75, 1'b0, -1);
        push_ev(1'b0, 8'h75, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h75, 1'b0, -1);
        push_ev(1'b0, 8'h29, 1'b1, 1'b0);
        send_byte(8'h29, 1'b0, -1);

        push_ev(1'b0, 8'h6B, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'hE0, 1'b0, -1);
        send_byte(8'h6B, 1'b0, -1);

`ifdef PS2_PARITY_CHECK_EN
        push_ev(1'b1, last_scan, 1'b0, 1'b0);
`else
        push_ev(1'b0, 8'h16, 1'b1, 1'b0);
`endif
        send_byte(8'h16, 1'b1, -1);

        push_ev(1'b1, last_scan, 1'b0, 1'b0);
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, -1);
        wait_cyc(3125 + 200);
        chk("tmo_drained", exp_q.size(), 32'd0);

        push_ev(1'b0, 8'h29, 1'b1, 1'b0);
        send_byte(8'h29, 1'b0, -1);

        push_ev(1'b0, 8'h5A, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b0, 3);

        push_ev(1'b0, 8'h1C, 1'b1, 1'b0);
        foreach (pause_seq[i])
            send_byte(pause_seq[i], 1'b0, -1);
        send_byte(8'h1C, 1'b0, -1);

        wait_cyc(50);
        chk("final_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

endmodule
